// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : READ-command sequencer for SPI NOR flash. It sits upstream of a
//               mode-0 byte-handshake SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter logic [7:0] READ_CMD      = 8'h03,
    parameter int         LEN_W         = 16,
    parameter int         CS_SETUP_CLKS = 4,
    parameter int         CS_HOLD_CLKS  = 4,
    parameter logic [7:0] DUMMY_BYTE    = 8'h00
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Req,
    input  logic [23:0]      i_Addr,
    input  logic [LEN_W-1:0] i_Len,
    output logic             o_Busy,
    output logic [7:0]       o_Data,
    output logic             o_Data_Valid,
    output logic             o_Done,
    output logic             o_SPI_CS_n,
    output logic [7:0]       o_TX_Byte,
    output logic             o_TX_DV,
    input  logic             i_TX_Ready,
    input  logic             i_RX_DV,
    input  logic [7:0]       i_RX_Byte
);

    localparam int C_CNT_MAX = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_IDX_W   = LEN_W + 1;

    localparam logic [C_CNT_W-1:0] C_SETUP_LAST = C_CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST  = C_CNT_W'(CS_HOLD_CLKS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE    = C_IDX_W'(1);
    localparam logic [C_IDX_W-1:0] C_HDR_BYTES  = C_IDX_W'(4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t             r_state_q,      w_state_d;
    logic [23:0]        r_addr_q,       w_addr_d;
    logic [LEN_W-1:0]   r_len_q,        w_len_d;
    logic [C_IDX_W-1:0] r_idx_q,        w_idx_d;
    logic [C_CNT_W-1:0] r_cnt_q,        w_cnt_d;
    logic               r_hold_run_q,   w_hold_run_d;
    logic               r_cs_n_q,       w_cs_n_d;
    logic               r_tx_dv_q,      w_tx_dv_d;
    logic [7:0]         r_tx_byte_q,    w_tx_byte_d;
    logic [7:0]         r_data_q,       w_data_d;
    logic               r_data_valid_q, w_data_valid_d;
    logic               r_done_q,       w_done_d;
    logic               r_busy_q,       w_busy_d;

    logic               w_accept;
    logic [7:0]         w_tx_sel;
    logic [C_IDX_W-1:0] w_idx_inc;
    logic [C_IDX_W-1:0] w_total;

    // busy_q still covers the Done cycle, so a request there is not accepted
    assign w_accept  = (r_state_q == S_IDLE) && i_Req && !r_busy_q;
    assign w_idx_inc = r_idx_q + C_IDX_ONE;
    assign w_total   = C_HDR_BYTES + C_IDX_W'(r_len_q);

    always_comb begin
        w_tx_sel = DUMMY_BYTE;
        if (r_idx_q == '0) begin
            w_tx_sel = READ_CMD;
        end else if (r_idx_q == C_IDX_W'(1)) begin
            w_tx_sel = r_addr_q[23:16];
        end else if (r_idx_q == C_IDX_W'(2)) begin
            w_tx_sel = r_addr_q[15:8];
        end else if (r_idx_q == C_IDX_W'(3)) begin
            w_tx_sel = r_addr_q[7:0];
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_addr_d       = r_addr_q;
        w_len_d        = r_len_q;
        w_idx_d        = r_idx_q;
        w_cnt_d        = r_cnt_q;
        w_hold_run_d   = r_hold_run_q;
        w_cs_n_d       = r_cs_n_q;
        w_tx_dv_d      = 1'b0;
        w_tx_byte_d    = r_tx_byte_q;
        w_data_d       = r_data_q;
        w_data_valid_d = 1'b0;
        w_done_d       = 1'b0;
        w_busy_d       = (r_state_q != S_IDLE) || w_accept;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_addr_d     = i_Addr;
                    w_len_d      = i_Len;
                    w_idx_d      = '0;
                    w_cnt_d      = '0;
                    w_hold_run_d = 1'b0;
                    if (i_Len == '0) begin
                        w_state_d = S_FINISH;
                    end else begin
                        w_cs_n_d  = 1'b0;
                        w_state_d = S_SETUP;
                    end
                end
            end

            // The last setup cycle doubles as the first issue attempt so that
            // the first TX_DV lands exactly CS_SETUP_CLKS after CS falls.
            S_SETUP: begin
                if (r_cnt_q == C_SETUP_LAST) begin
                    if (i_TX_Ready) begin
                        w_tx_dv_d   = 1'b1;
                        w_tx_byte_d = w_tx_sel;
                        w_state_d   = S_WAIT;
                    end else begin
                        w_state_d = S_ISSUE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + C_CNT_ONE;
                end
            end

            S_ISSUE: begin
                if (i_TX_Ready) begin
                    w_tx_dv_d   = 1'b1;
                    w_tx_byte_d = w_tx_sel;
                    w_state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_RX_DV) begin
                    if (r_idx_q >= C_HDR_BYTES) begin
                        w_data_d       = i_RX_Byte;
                        w_data_valid_d = 1'b1;
                    end
                    w_idx_d   = w_idx_inc;
                    w_state_d = (w_idx_inc < w_total) ? S_ISSUE : S_HOLD;
                end
            end

            // Ready sampled high counts as hold cycle 1; CS rises on cycle N.
            S_HOLD: begin
                if (!r_hold_run_q) begin
                    if (i_TX_Ready) begin
                        if (C_HOLD_LAST == '0) begin
                            w_cs_n_d  = 1'b1;
                            w_state_d = S_FINISH;
                        end else begin
                            w_hold_run_d = 1'b1;
                            w_cnt_d      = C_CNT_ONE;
                        end
                    end
                end else if (r_cnt_q == C_HOLD_LAST) begin
                    w_hold_run_d = 1'b0;
                    w_cs_n_d     = 1'b1;
                    w_state_d    = S_FINISH;
                end else begin
                    w_cnt_d = r_cnt_q + C_CNT_ONE;
                end
            end

            S_FINISH: begin
                w_done_d  = 1'b1;
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state_q      <= S_IDLE;
            r_addr_q       <= '0;
            r_len_q        <= '0;
            r_idx_q        <= '0;
            r_cnt_q        <= '0;
            r_hold_run_q   <= 1'b0;
            r_cs_n_q       <= 1'b1;
            r_tx_dv_q      <= 1'b0;
            r_tx_byte_q    <= '0;
            r_data_q       <= '0;
            r_data_valid_q <= 1'b0;
            r_done_q       <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_len_q        <= w_len_d;
            r_idx_q        <= w_idx_d;
            r_cnt_q        <= w_cnt_d;
            r_hold_run_q   <= w_hold_run_d;
            r_cs_n_q       <= w_cs_n_d;
            r_tx_dv_q      <= w_tx_dv_d;
            r_tx_byte_q    <= w_tx_byte_d;
            r_data_q       <= w_data_d;
            r_data_valid_q <= w_data_valid_d;
            r_done_q       <= w_done_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign o_Busy       = r_busy_q;
    assign o_Data       = r_data_q;
    assign o_Data_Valid = r_data_valid_q;
    assign o_Done       = r_done_q;
    assign o_SPI_CS_n   = r_cs_n_q;
    assign o_TX_Byte    = r_tx_byte_q;
    assign o_TX_DV      = r_tx_dv_q;

endmodule
`default_nettype wire
